// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle RV32M MUL / DIVU / REMU sequencer that borrows the shared datapath ALU,
// issuing one ALU operation per cycle (shift-add multiply, restoring divide).
module alu_muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [2:0]       alu_control,
  output logic             alu_is_slt,
  output logic             alu_is_u,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_STEP, S_DIV_CMP, S_DIV_SUB, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: product accumulator / partial remainder; opb: multiplicand / divisor;
  // opc: multiplier / quotient shift register
  logic [WIDTH-1:0] acc_q, acc_d, opb_q, opb_d, opc_q, opc_d, sh_q, sh_d;
  logic             ge_q, ge_d;
  logic             busy_q, busy_d, done_q, done_d, own_q, own_d;
  logic             slt_q, slt_d, u_q, u_d;
  logic [WIDTH-1:0] result_q, result_d, src_a_q, src_a_d, src_b_q, src_b_d;
  logic [2:0]       ctrl_q, ctrl_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    sh_d     = sh_q;
    ge_d     = ge_q;
    result_d = result_q;
    own_d    = 1'b0;
    src_a_d  = '0;
    src_b_d  = '0;
    ctrl_d   = ALU_ADD;
    slt_d    = 1'b0;
    u_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          case (op)
            OP_MUL: begin
              acc_d   = '0;
              opb_d   = operand_a;
              opc_d   = operand_b;
              state_d = S_MUL_STEP;
            end
            OP_DIVU, OP_REMU: begin
              if (operand_b == '0) begin
                result_d = (op == OP_DIVU) ? '1 : operand_a;
                state_d  = S_DONE;
              end else begin
                acc_d   = '0;
                opb_d   = operand_b;
                opc_d   = operand_a;
                state_d = S_DIV_CMP;
              end
            end
            default: begin
              result_d = '0;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_MUL_STEP: begin
        if (opc_q[0]) acc_d = alu_result;
        opb_d = {opb_q[WIDTH-2:0], 1'b0};
        opc_d = {1'b0, opc_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          result_d = acc_d;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV_CMP: begin
        // A set remainder MSB means the shifted value exceeds WIDTH bits, so it is >= divisor
        sh_d    = {acc_q[WIDTH-2:0], opc_q[WIDTH-1]};
        ge_d    = acc_q[WIDTH-1] | ~alu_result[0];
        state_d = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        acc_d = ge_q ? alu_result : sh_q;
        opc_d = {opc_q[WIDTH-2:0], ge_q};
        if (cnt_q == CNT_LAST) begin
          result_d = (op_q == OP_REMU) ? acc_d : opc_d;
          state_d  = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_DIV_CMP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);

    // ALU drive is registered, so it is computed from the values the next state will see
    case (state_d)
      S_MUL_STEP: begin
        own_d   = 1'b1;
        src_a_d = acc_d;
        src_b_d = opb_d;
      end
      S_DIV_CMP: begin
        own_d   = 1'b1;
        src_a_d = {acc_d[WIDTH-2:0], opc_d[WIDTH-1]};
        src_b_d = opb_d;
        ctrl_d  = ALU_SUB;
        slt_d   = 1'b1;
        u_d     = 1'b1;
      end
      S_DIV_SUB: begin
        own_d   = 1'b1;
        src_a_d = sh_d;
        src_b_d = opb_d;
        ctrl_d  = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      sh_q     <= '0;
      ge_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      own_q    <= 1'b0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      ctrl_q   <= '0;
      slt_q    <= 1'b0;
      u_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      opc_q    <= opc_d;
      sh_q     <= sh_d;
      ge_q     <= ge_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      own_q    <= own_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      ctrl_q   <= ctrl_d;
      slt_q    <= slt_d;
      u_q      <= u_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign alu_own     = own_q;
  assign alu_src_a   = src_a_q;
  assign alu_src_b   = src_b_q;
  assign alu_control = ctrl_q;
  assign alu_is_slt  = slt_q;
  assign alu_is_u    = u_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: models the shared ALU and checks results, latency and
// ALU ownership against plain-arithmetic RV32M reference behaviour.
module tb_alu_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done, alu_own, alu_is_slt, alu_is_u;
  logic [31:0] result, alu_src_a, alu_src_b, alu_result;
  logic [2:0]  alu_control;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result),
    .alu_own(alu_own), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .alu_is_slt(alu_is_slt), .alu_is_u(alu_is_u),
    .alu_result(alu_result)
  );

  // Shared datapath ALU
  always_comb begin
    if (alu_is_slt)
      alu_result = alu_is_u ? {31'd0, alu_src_a < alu_src_b}
                            : {31'd0, $signed(alu_src_a) < $signed(alu_src_b)};
    else if (alu_control == 3'b001)
      alu_result = alu_src_a - alu_src_b;
    else
      alu_result = alu_src_a + alu_src_b;
  end

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] b);
    if (o == 2'b00) return 33;
    if ((o == 2'b01 || o == 2'b10) && b != 0) return 65;
    return 1;
  endfunction

  // Issue one request and watch it to completion; returns observations only
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, b,
                        output logic [31:0] res, output int lat, output int own,
                        output logic busy_ok, output logic idle_bus_ok);
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk);
    lat = 0; own = 0; got = 0; busy_ok = 1'b1; idle_bus_ok = 1'b1; res = 'x;
    while (lat < 300 && !got) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (alu_own) own++;
      if (!busy) busy_ok = 1'b0;
      if (!alu_own && (alu_src_a != 0 || alu_src_b != 0 || alu_control != 0 ||
                       alu_is_slt || alu_is_u)) idle_bus_ok = 1'b0;
      if (done) begin got = 1; res = result; end
      else @(posedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    #13;
    checks++;
    if ({busy, done, alu_own, alu_is_slt, alu_is_u} !== 5'b0 || result !== 32'd0 ||
        alu_src_a !== 32'd0 || alu_src_b !== 32'd0 || alu_control !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b own=%b result=%h srca=%h srcb=%h ctrl=%h required all zero",
               busy, done, alu_own, result, alu_src_a, alu_src_b, alu_control);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [12] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10,
                              2'b01, 2'b10, 2'b11, 2'b00};
    logic [31:0] as [12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd100, 32'd100,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5,
                             32'd9, 32'd0};
    logic [31:0] bs [12] = '{32'd6, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd7, 32'd1,
                             32'h8000_0001, 32'h8000_0001, 32'd0, 32'd0, 32'd3, 32'd12345};
    logic [31:0] exp [12] = '{32'd42, 32'd1, 32'd0, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd1,
                              32'h7FFF_FFFE, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0};
    logic [31:0] res;
    int lat, own;
    logic bok, iok;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, own, bok, iok);
      checks++;
      if (res !== exp[i] || lat != ref_latency(ops[i], bs[i])) begin
        failures++;
        $display("FAIL directed_%0d: result=%h latency=%0d required result=%h latency=%0d",
                 i, res, lat, exp[i], ref_latency(ops[i], bs[i]));
      end
      checks++;
      if (own != ref_latency(ops[i], bs[i]) - 1 || !bok || !iok) begin
        failures++;
        $display("FAIL directed_own_%0d: own_cycles=%0d busy_ok=%b idle_bus_ok=%b required own_cycles=%0d busy_ok=1 idle_bus_ok=1",
                 i, own, bok, iok, ref_latency(ops[i], bs[i]) - 1);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, res;
    int lat, own;
    logic bok, iok;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      run_op(o, a, b, res, lat, own, bok, iok);
      checks++;
      if (res !== ref_result(o, a, b) || lat != ref_latency(o, b) || !iok) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h latency=%0d idle_bus_ok=%b required result=%h latency=%0d",
                 i, o, a, b, res, lat, iok, ref_result(o, a, b), ref_latency(o, b));
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd7; operand_b = 32'd6;
    @(posedge clk);
    lat = 0; got = 0;
    while (lat < 300 && !got) begin
      @(negedge clk);
      lat++;
      start = (lat == 10);
      if (lat == 10) begin op = 2'b01; operand_a = 32'd1000; operand_b = 32'd3; end
      if (done) got = 1;
      else @(posedge clk);
    end
    start = 1'b0;
    checks++;
    if (!got || result !== 32'd42 || lat != 33) begin
      failures++;
      $display("FAIL ignore_start: done=%b result=%h latency=%0d required done=1 result=0000002a latency=33",
               got, result, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2;
    int l1, l2, o1, o2;
    logic b1, b2, i1, i2;
    run_op(2'b10, 32'd1000, 32'd7, r1, l1, o1, b1, i1);
    run_op(2'b00, 32'd123, 32'd456, r2, l2, o2, b2, i2);
    checks++;
    if (r1 !== 32'd6 || r2 !== 32'd56088 || l1 != 65 || l2 != 33) begin
      failures++;
      $display("FAIL back_to_back: r1=%h l1=%0d r2=%h l2=%0d required r1=00000006 l1=65 r2=0000db18 l2=33",
               r1, l1, r2, l2);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd56088) begin
      failures++;
      $display("FAIL result_hold: done=%b busy=%b result=%h required done=0 busy=0 result=0000db18",
               done, busy, result);
    end
  endtask

  task automatic test_reset_midop;
    logic [31:0] res;
    int lat, own;
    logic bok, iok, saw_done;
    @(negedge clk);
    start = 1'b1; op = 2'b01; operand_a = 32'd5000; operand_b = 32'd9;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_own !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_midop: busy=%b done=%b own=%b result=%h required all zero",
               busy, done, alu_own, result);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c == 2) reset_n = 1'b1;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abandoned_no_done: saw done=1 required done=0 after reset");
    end
    run_op(2'b00, 32'hDEAD_BEEF, 32'd3, res, lat, own, bok, iok);
    checks++;
    if (res !== ref_result(2'b00, 32'hDEAD_BEEF, 32'd3) || lat != 33) begin
      failures++;
      $display("FAIL mul_after_reset: result=%h latency=%0d required result=%h latency=33",
               res, lat, ref_result(2'b00, 32'hDEAD_BEEF, 32'd3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
